afifo_rd_stream: RTL and testbench
==================================

# afifo_rd_stream

Read-side consumer for the async FIFO, clocked entirely in the read domain. It drains the FIFO's empty/increment read port and re-presents the words as a registered valid/ready stream. It tags every BURST-th word with a last marker and keeps a saturating count of delivered words. It sits between the FIFO read port and any downstream read-domain logic.

## Interface
Parameters:
- DSIZE, 8, data word width; matches the FIFO's DSIZE.
- BURST, 4, words per burst; `out_last` marks word BURST-1 of each burst; legal range 1..256.
- CNT_W, 16, width of `word_count`.

Ports:
- rd_clk  input  1  read-domain clock; the only clock.
- rd_rst  input  1  asynchronous, active-low reset.
- rd_data  input  DSIZE  FIFO read data; valid whenever `rd_empty`=0 (first-word fall-through).
- rd_empty  input  1  FIFO empty flag, synchronous to `rd_clk`.
- rd_inc  output  1  FIFO pop strobe; the word on `rd_data` is consumed on the `rd_clk` edge where this is 1.
- en  input  1  drain enable.
- out_data  output  DSIZE  head word of the output buffer.
- out_valid  output  1  head word present.
- out_last  output  1  head word is the last word of a burst.
- out_ready  input  1  downstream accepts the head word.
- word_count  output  CNT_W  saturating count of accepted output words.
- busy  output  1  state ≠ IDLE.

## Operation
- Internal 2-entry buffer holds {data, last} and an occupancy count `occ` of 0..2.
- `rd_inc = rd_rst & en & ~rd_empty & (occ < 2)`. This is combinational and forced to 0 while reset is asserted.
- Push: on an edge with `rd_inc`=1, capture `rd_data` and `last = (beat == BURST-1)`. `beat` then advances modulo BURST.
- Pop: on an edge with `out_valid & out_ready`, the head is removed and `word_count` increments, saturating at 2^CNT_W-1.
- Simultaneous push and pop at `occ`=1:
  - `occ` stays 1.
  - The new word becomes the head on the next cycle.
  - Sustained throughput is 1 word/cycle.
- Push at `occ`=2 cannot occur. Pop at `occ`=0 cannot occur, because `out_valid`=0.
- `out_valid = (occ != 0)`. `out_data` and `out_last` come from the head entry. When `occ`=0 they hold their last value and are ignored.
- Once asserted, `out_data`, `out_valid` and `out_last` stay stable until accepted.
- FSM, with transitions evaluated on each edge:
  - IDLE → RUN when `en`=1 and (`rd_empty`=0 or `occ`≠0).
  - RUN → DRAIN when `en`=0 and `occ`≠0 after this edge.
  - RUN → IDLE when `rd_empty`=1 and `occ`=0 after this edge (the FIFO is drained), or when `en`=0 and `occ`=0 after this edge.
  - DRAIN → IDLE when `occ` reaches 0.
  - DRAIN → RUN when `en` returns to 1.
- In DRAIN no pops are issued, but buffered words still leave.
- Deasserting `en` does not reset `beat`. Burst framing continues across pauses.

## Timing
- Reset (asynchronous, `rd_rst`=0) values:
  - `rd_inc`=0, `out_valid`=0, `out_last`=0, `out_data`=0.
  - `word_count`=0, `busy`=0.
  - `occ`=0, `beat`=0, state=IDLE.
- Reset mid-operation discards buffered words. Any word not yet popped stays in the FIFO.
- Latency: a word popped on edge N appears on `out_out` ports with `out_valid`=1 after edge N, i.e. in cycle N+1, when the buffer was empty.
- `rd_empty` rising in the same cycle as a would-be pop means no pop, because `rd_inc` follows the current `rd_empty`.
- `word_count` saturates at its maximum and holds there; it does not wrap.
- `beat` wraps from BURST-1 to 0. With BURST=1, every word has `last`=1.

## Structure
- Shared package `afifo_pkg`:
  - state enum `rd_state_e` {IDLE, RUN, DRAIN};
  - default DSIZE/ASIZE constants used by the FIFO and its bench.
- Sub-module `afifo_skid_buf`: the parameterised 2-entry {data, last} buffer with push/pop/occ.
- The top level holds the FSM, `beat` counter, `word_count` and `rd_inc` logic.

## Test plan
- Reset with FIFO preloaded with 0x11..0x14, `en`=1, `out_ready`=1 → `rd_inc` high 4 cycles; outputs 0x11..0x14 on consecutive cycles starting 1 cycle after first pop; `out_last`=1 on 0x14 only; `word_count`=4; `busy` falls after drain.
- `out_ready`=0 with 5 words in FIFO → exactly 2 pops, `rd_inc` then stays 0, `out_data`=first word held stable; raising `out_ready` delivers all 5 in order.
- `en` dropped with `occ`=2 → state DRAIN, no further `rd_inc`, 2 words delivered, then IDLE; re-enable resumes with correct `beat` (9 total words with BURST=4 gives `out_last` on words 4 and 8).
- Async `rd_rst` pulse mid-burst → all outputs 0 immediately; after release, the first word pushed gets `beat`=0.
- CNT_W=3, 10 accepted words → `word_count` stays at 7.
- Random `rd_empty`/`out_ready` toggling, 1000 words → scoreboard order/data match, no pop while `rd_empty`=1, `out_last` every 4th word.

Source files
------------

// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO and its read-side stream consumer.
package afifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;

  function automatic logic [1:0] occ_after(input logic [1:0] occ,
                                           input logic       push,
                                           input logic       pop);
    return occ + {1'b0, push} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/afifo_skid_buf.sv
// Two-entry {data,last} buffer; a pushed word is the head one cycle later when empty.
// Push must not occur when full; pop must not occur when empty.
module afifo_skid_buf #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          push_last,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          head_last,
  output logic [1:0]    occ
);
  import afifo_pkg::*;

  logic [DW-1:0] head_data_q, head_data_d;
  logic          head_last_q, head_last_d;
  logic [DW-1:0] tail_data_q, tail_data_d;
  logic          tail_last_q, tail_last_d;
  logic [1:0]    occ_q, occ_d;

  always_comb begin
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    occ_d       = occ_after(occ_q, push, pop);
    if (pop && occ_q == 2'd2) begin
      head_data_d = tail_data_q;
      head_last_d = tail_last_q;
    end
    // With one word held, a push lands in the head only if that word leaves now.
    if (push) begin
      if (occ_q == 2'd0 || pop) begin
        head_data_d = push_data;
        head_last_d = push_last;
      end else begin
        tail_data_d = push_data;
        tail_last_d = push_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
      occ_q       <= occ_d;
    end
  end

  assign head_data = head_data_q;
  assign head_last = head_last_q;
  assign occ       = occ_q;

endmodule

// File: rtl/afifo_rd_stream.sv
// Drains the FIFO read port into a registered valid/ready stream with burst framing; 1-cycle latency.
// Backpressure: FIFO pops stop once the 2-entry buffer is full; held words stay stable until accepted.
module afifo_rd_stream
  import afifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int BURST = 4,
  parameter int CNT_W = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [DSIZE-1:0] rd_data,
  input  logic             rd_empty,
  output logic             rd_inc,
  input  logic             en,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_count,
  output logic             busy
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  logic [BW-1:0]    beat_q, beat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rd_state_e        state_q, state_d;
  logic [1:0]       occ, occ_nxt;
  logic             pop, push_last;

  assign rd_inc    = rd_rst & en & ~rd_empty & (occ < 2'd2);
  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push_last = (beat_q == BW'(BURST - 1));
  assign occ_nxt   = occ_after(occ, rd_inc, pop);

  afifo_skid_buf #(.DW(DSIZE)) u_buf (
    .clk       (rd_clk),
    .rst_n     (rd_rst),
    .push      (rd_inc),
    .push_data (rd_data),
    .push_last (push_last),
    .pop       (pop),
    .head_data (out_data),
    .head_last (out_last),
    .occ       (occ)
  );

  always_comb begin
    beat_d = beat_q;
    cnt_d  = cnt_q;
    if (rd_inc) beat_d = push_last ? '0 : beat_q + BW'(1);
    if (pop && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (en && (!rd_empty || occ != 2'd0)) state_d = RUN;
      RUN: begin
        if (!en && occ_nxt != 2'd0)                        state_d = DRAIN;
        else if ((!en || rd_empty) && occ_nxt == 2'd0)     state_d = IDLE;
      end
      DRAIN: begin
        if (en)                     state_d = RUN;
        else if (occ_nxt == 2'd0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      beat_q  <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign word_count = cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Bench: FIFO model feeds two instances (BURST=4/CNT_W=16 and BURST=1/CNT_W=3); scoreboard checks the stream.
module tb_afifo_rd_stream;

  logic       rd_clk = 1'b0;
  logic       rd_rst, en, rd_empty, out_ready;
  logic [7:0] rd_data;

  logic        rd_inc, out_valid, out_last, busy;
  logic [7:0]  out_data;
  logic [15:0] word_count;
  logic        rd_inc_b, out_valid_b, out_last_b, busy_b;
  logic [7:0]  out_data_b;
  logic [2:0]  word_count_b;

  always #5 rd_clk = ~rd_clk;

  afifo_rd_stream #(.DSIZE(8), .BURST(4), .CNT_W(16)) u_dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_inc(rd_inc), .en(en), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .word_count(word_count), .busy(busy)
  );

  afifo_rd_stream #(.DSIZE(8), .BURST(1), .CNT_W(3)) u_dut_b (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_inc(rd_inc_b), .en(en), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_last(out_last_b), .out_ready(out_ready), .word_count(word_count_b), .busy(busy_b)
  );

  typedef struct { logic [7:0] d; logic l; } exp_t;
  typedef struct {
    logic en, rdy, inc, vld;
    logic [7:0] d;
    logic l, bsy;
    logic [15:0] wc;
  } vec_t;

  exp_t       sb[$];
  logic [7:0] fq[$];
  int tests = 0, fails = 0;
  int cnt = 0, beat_m = 0, inc_seen = 0, last_seen = 0;
  bit hold_empty = 0, prev_stall = 0;
  logic [7:0] prev_d;
  logic       prev_l;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called just after a falling edge: drive FIFO side, sample, check, update models.
  task automatic sample();
    exp_t e;
    rd_empty = hold_empty || (fq.size() == 0);
    rd_data  = (fq.size() != 0) ? fq[0] : 8'h00;
    #1;
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_d);
      chk("hold_last", out_last, prev_l);
    end
    if (rd_inc) chk("pop_while_empty", rd_empty, 0);
    if (out_valid_b) chk("burst1_last", out_last_b, 1);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_last", out_last, e.l);
        if (out_last) last_seen++;
      end
      cnt++;
    end
    if (rd_inc && !rd_empty) begin
      e.d = fq.pop_front();
      e.l = (beat_m == 3);
      sb.push_back(e);
      beat_m = (beat_m + 1) % 4;
      inc_seen++;
    end
    prev_stall = out_valid && !out_ready;
    prev_d = out_data;
    prev_l = out_last;
  endtask

  task automatic advance();
    @(posedge rd_clk);
    @(negedge rd_clk);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && (sb.size() != 0 || fq.size() != 0); i++) begin
      sample();
      advance();
    end
    chk("drain_timeout", sb.size() + fq.size(), 0);
    sample();
    advance();
  endtask

  task automatic check_counts();
    chk("word_count", word_count, cnt);
    chk("word_count_sat", word_count_b, (cnt > 7) ? 7 : cnt);
  endtask

  initial begin
    vec_t tbl[6];
    tbl[0] = '{1, 1, 1, 0, 8'h00, 0, 0, 16'd0};
    tbl[1] = '{1, 1, 1, 1, 8'h11, 0, 1, 16'd0};
    tbl[2] = '{1, 1, 1, 1, 8'h12, 0, 1, 16'd1};
    tbl[3] = '{1, 1, 1, 1, 8'h13, 0, 1, 16'd2};
    tbl[4] = '{1, 1, 0, 1, 8'h14, 1, 1, 16'd3};
    tbl[5] = '{1, 1, 0, 0, 8'h14, 1, 0, 16'd4};

    rd_rst = 1'b1; en = 1'b1; out_ready = 1'b1; rd_empty = 1'b0; rd_data = 8'h11;
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'h11 + i));
    #1 rd_rst = 1'b0;
    advance();
    #1;
    chk("rst_rd_inc", rd_inc, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_busy", busy, 0);
    @(negedge rd_clk);
    rd_rst = 1'b1;

    // Preloaded burst at full rate
    for (int i = 0; i < 6; i++) begin
      en = tbl[i].en; out_ready = tbl[i].rdy;
      sample();
      chk($sformatf("t%0d_rd_inc", i), rd_inc, tbl[i].inc);
      chk($sformatf("t%0d_valid", i), out_valid, tbl[i].vld);
      chk($sformatf("t%0d_data", i), out_data, tbl[i].d);
      chk($sformatf("t%0d_last", i), out_last, tbl[i].l);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("t%0d_wc", i), word_count, tbl[i].wc);
      advance();
    end

    // Backpressure: only two pops while out_ready is low
    for (int i = 0; i < 5; i++) fq.push_back(8'(8'h21 + i));
    out_ready = 1'b0; inc_seen = 0;
    for (int i = 0; i < 6; i++) begin sample(); advance(); end
    chk("bp_pops", inc_seen, 2);
    #1 chk("bp_head", out_data, 8'h21);
    out_ready = 1'b1;
    drain(50);
    check_counts();

    // Asynchronous reset mid-burst
    for (int i = 0; i < 6; i++) fq.push_back(8'(8'h31 + i));
    for (int i = 0; i < 2; i++) begin sample(); advance(); end
    rd_empty = 1'b0; rd_data = fq[0];
    #2 rd_rst = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_last", out_last, 0);
    chk("arst_rd_inc", rd_inc, 0);
    chk("arst_busy", busy, 0);
    chk("arst_wc", word_count, 0);
    advance();
    rd_rst = 1'b1;
    sb.delete(); cnt = 0; beat_m = 0; prev_stall = 0;
    drain(50);
    check_counts();

    // Drop en with a full buffer, drain, then resume
    for (int i = 0; i < 9; i++) fq.push_back(8'(8'h41 + i));
    last_seen = 0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin sample(); advance(); end
    en = 1'b0; out_ready = 1'b1;
    sample();
    chk("drain_a_inc", rd_inc, 0);
    chk("drain_a_busy", busy, 1);
    advance();
    sample();
    chk("drain_b_inc", rd_inc, 0);
    chk("drain_b_busy", busy, 1);
    chk("drain_b_valid", out_valid, 1);
    advance();
    sample();
    chk("drain_c_inc", rd_inc, 0);
    chk("drain_c_busy", busy, 0);
    chk("drain_c_valid", out_valid, 0);
    advance();
    en = 1'b1;
    drain(60);
    chk("resume_lasts", last_seen, 2);
    check_counts();

    // Random empty/ready toggling over 1000 words
    for (int i = 0; i < 1000; i++) fq.push_back(8'($urandom));
    for (int i = 0; i < 20000 && (sb.size() != 0 || fq.size() != 0); i++) begin
      hold_empty = ($urandom % 3) == 0;
      out_ready  = ($urandom % 4) != 0;
      sample();
      advance();
    end
    hold_empty = 0; out_ready = 1'b1;
    drain(50);
    check_counts();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
